// File: rtl/dial_pkg.sv
// Shared constants and direction encoding for the dial accumulator.
package dial_pkg;

  localparam int DIAL_ANGLE_W  = 4;
  localparam int DIAL_DIV_SLOW = 8;
  localparam int DIAL_DIV_FAST = 2;
  localparam int DIAL_FRAC_W   = 3;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CW   = 2'd1,
    CCW  = 2'd2
  } dial_dir_t;

  // Pressing both buttons, or neither, means no rotation.
  function automatic dial_dir_t dir_decode(input logic plus, input logic minus);
    dial_dir_t d;
    d = NONE;
    if (plus && !minus) begin
      d = CW;
    end else if (minus && !plus) begin
      d = CCW;
    end
    return d;
  endfunction

endpackage

// File: rtl/edge_toggle_det.sv
// Single-bit event detector.
//   TOGGLE_MODE=0: rising-edge detector (strobe pacing).
//   TOGGLE_MODE=1: level-change detector, suppressed until the first clock
//                  after reset release so the toggle level present at release
//                  is never mistaken for a new sample.
module edge_toggle_det #(
  parameter bit TOGGLE_MODE = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sig_in,
  output logic event_out
);

  logic sig_d;
  logic armed;

  // Previous-sample register and post-reset arming flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sig_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_d <= sig_in;
      armed <= 1'b1;
    end
  end

  assign event_out = TOGGLE_MODE ? (armed & (sig_in ^ sig_d))
                                 : (sig_in & ~sig_d);

endmodule

// File: rtl/dial_accumulator.sv
// Converts held rotate buttons and spinner deltas into an absolute dial
// angle. State is a single fixed-point accumulator; the angle is its integer
// part. Button steps are paced by strobe rising edges through a prescaler;
// spinner deltas are added whenever the sample toggle bit changes.
module dial_accumulator
  import dial_pkg::*;
#(
  parameter int ANGLE_W  = DIAL_ANGLE_W,
  parameter int DIV_SLOW = DIAL_DIV_SLOW,
  parameter int DIV_FAST = DIAL_DIV_FAST,
  parameter int FRAC_W   = DIAL_FRAC_W
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               plus,
  input  logic               minus,
  input  logic               fast,
  input  logic               strobe,
  input  logic [8:0]         spin_in,
  output logic [ANGLE_W-1:0] spin_out,
  output logic               moved
);

  localparam int ACC_W   = ANGLE_W + FRAC_W;
  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int PRE_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  // One whole angle step in accumulator units, and its two's complement.
  localparam logic [ACC_W-1:0] STEP_POS = ACC_W'(1) << FRAC_W;
  localparam logic [ACC_W-1:0] STEP_NEG = ACC_W'(0) - STEP_POS;

  logic             strobe_rise;
  logic             spin_update;
  dial_dir_t        dir;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_next;
  logic [PRE_W-1:0] div_m1;
  logic             step_fire;
  logic [ACC_W-1:0] step_acc;
  logic [ACC_W-1:0] delta_acc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  edge_toggle_det #(.TOGGLE_MODE(1'b0)) u_strobe_det (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .sig_in    (strobe),
    .event_out (strobe_rise)
  );

  edge_toggle_det #(.TOGGLE_MODE(1'b1)) u_spin_det (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .sig_in    (spin_in[8]),
    .event_out (spin_update)
  );

  // Prescaler: count strobe edges while a direction is held; the >= compare
  // lets a mid-count switch to a shorter divider fire on the next edge.
  always_comb begin
    dir       = dir_decode(plus, minus);
    div_m1    = fast ? PRE_W'(DIV_FAST - 1) : PRE_W'(DIV_SLOW - 1);
    pre_next  = pre;
    step_fire = 1'b0;
    if (strobe_rise) begin
      if (dir == NONE) begin
        pre_next = '0;
      end else if (pre >= div_m1) begin
        pre_next  = '0;
        step_fire = 1'b1;
      end else begin
        pre_next = pre + PRE_W'(1);
      end
    end
  end

  // Next accumulator value: digital step and analog delta summed together,
  // wrapping modulo 2^ACC_W.
  always_comb begin
    step_acc = '0;
    if (step_fire) begin
      step_acc = (dir == CW) ? STEP_POS : STEP_NEG;
    end
    delta_acc = '0;
    if (spin_update) begin
      for (int i = 0; i < ACC_W; i++) begin
        delta_acc[i] = spin_in[(i < 8) ? i : 7];
      end
    end
    acc_next = acc + step_acc + delta_acc;
  end

  // Accumulator, prescaler and one-cycle moved pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      pre   <= '0;
      moved <= 1'b0;
    end else begin
      acc   <= acc_next;
      pre   <= pre_next;
      moved <= (acc_next[ACC_W-1:FRAC_W] != acc[ACC_W-1:FRAC_W]);
    end
  end

  assign spin_out = acc[ACC_W-1:FRAC_W];

endmodule

// File: tb/tb_dial_accumulator.sv
// Bench for dial_accumulator: directed scenarios followed by random traffic,
// all checked against an arithmetic model of the dial angle.
module tb_dial_accumulator;

  localparam int AW  = 4;
  localparam int FW  = 3;
  localparam int DS  = 8;
  localparam int DF  = 2;
  localparam int MOD = 1 << (AW + FW);

  // Clock/reset and DUT signals
  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          plus    = 1'b0;
  logic          minus   = 1'b0;
  logic          fast    = 1'b0;
  logic          strobe  = 1'b0;
  logic [8:0]    spin_in = '0;
  logic [AW-1:0] spin_out;
  logic          moved;

  int checks     = 0;
  int failures   = 0;
  int moved_seen = 0;

  // Reference model state: angle in fractional units and edges since last step.
  int m_acc;
  int m_cnt;
  bit m_strobe_prev;
  bit m_tog_prev;
  bit m_armed;

  dial_accumulator #(
    .ANGLE_W  (AW),
    .DIV_SLOW (DS),
    .DIV_FAST (DF),
    .FRAC_W   (FW)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .plus     (plus),
    .minus    (minus),
    .fast     (fast),
    .strobe   (strobe),
    .spin_in  (spin_in),
    .spin_out (spin_out),
    .moved    (moved)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc         = 0;
    m_cnt         = 0;
    m_strobe_prev = 0;
    m_tog_prev    = 0;
    m_armed       = 0;
  endtask

  // One clock: predict from current inputs, clock, then compare outputs.
  task automatic cycle(input string tag);
    int  total;
    int  d;
    int  div;
    int  old_acc;
    byte sd;
    bit  exp_moved;
    total     = 0;
    exp_moved = 0;
    if (reset_n) begin
      if (strobe && !m_strobe_prev) begin
        d   = (plus && !minus) ? 1 : ((minus && !plus) ? -1 : 0);
        div = fast ? DF : DS;
        if (d == 0) begin
          m_cnt = 0;
        end else if (m_cnt + 1 >= div) begin
          m_cnt = 0;
          total += d * (1 << FW);
        end else begin
          m_cnt++;
        end
      end
      if (m_armed && (spin_in[8] != m_tog_prev)) begin
        sd = byte'(spin_in[7:0]);
        total += int'(sd);
      end
      old_acc       = m_acc;
      m_acc         = ((m_acc + total) % MOD + MOD) % MOD;
      exp_moved     = ((m_acc >> FW) != (old_acc >> FW));
      m_strobe_prev = strobe;
      m_tog_prev    = spin_in[8];
      m_armed       = 1;
    end
    @(posedge clk_sys);
    #1;
    chk({tag, " spin_out"}, 32'(spin_out), 32'(m_acc >> FW));
    chk({tag, " moved"}, 32'(moved), 32'(exp_moved));
    if (moved) moved_seen++;
    @(negedge clk_sys);
  endtask

  task automatic edges(input int n, input string tag);
    repeat (n) begin
      strobe = 1'b1;
      cycle(tag);
      strobe = 1'b0;
      cycle(tag);
    end
  endtask

  task automatic toggle(input logic [7:0] delta, input string tag);
    spin_in = {~spin_in[8], delta};
    cycle(tag);
    cycle(tag);
  endtask

  // Asynchronous reset taken between clock edges, then released.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, " async acc"}, 32'(dut.acc), 32'd0);
    chk({tag, " async pre"}, 32'(dut.pre), 32'd0);
    chk({tag, " async moved"}, 32'(moved), 32'd0);
    cycle(tag);
    cycle(tag);
    reset_n = 1'b1;
    cycle(tag);
  endtask

  initial begin
    // Reset held with toggle bit high: must not count as an update on release.
    model_reset();
    reset_n = 1'b0;
    spin_in = 9'h1FF;
    repeat (3) cycle("reset_hold");
    chk("reset spin_out", 32'(spin_out), 32'd0);
    chk("reset moved", 32'(moved), 32'd0);
    reset_n = 1'b1;
    repeat (3) cycle("release");
    chk("release spin_out", 32'(spin_out), 32'd0);

    // Slow then fast stepping.
    plus = 1'b1;
    fast = 1'b0;
    edges(16, "slow");
    chk("slow 16 edges", 32'(spin_out), 32'd2);
    fast = 1'b1;
    edges(8, "fast");
    chk("fast 8 edges", 32'(spin_out), 32'd6);

    // Wrap below zero, then conflicting buttons.
    plus = 1'b0;
    fast = 1'b0;
    do_reset("rst_wrap");
    minus = 1'b1;
    edges(8, "wrap");
    chk("wrap to 15", 32'(spin_out), 32'd15);
    plus = 1'b1;
    edges(20, "conflict");
    chk("conflict spin_out", 32'(spin_out), 32'd15);
    chk("conflict pre", 32'(dut.pre), 32'd0);

    // Analog deltas.
    plus  = 1'b0;
    minus = 1'b0;
    do_reset("rst_analog");
    moved_seen = 0;
    toggle(8'd12, "an_p12");
    chk("analog +12", 32'(spin_out), 32'd1);
    toggle(8'd4, "an_p4");
    chk("analog +4", 32'(spin_out), 32'd2);
    toggle(8'hE8, "an_m24");
    chk("analog -24", 32'(spin_out), 32'd15);
    chk("analog acc", 32'(dut.acc), 32'd120);
    chk("analog moved count", 32'(moved_seen), 32'd3);

    // Digital step and analog delta in the same cycle.
    do_reset("rst_simul");
    fast = 1'b1;
    plus = 1'b1;
    edges(1, "simul_pre");
    chk("simul pre", 32'(dut.pre), 32'd1);
    moved_seen = 0;
    strobe  = 1'b1;
    spin_in = {~spin_in[8], 8'd5};
    cycle("simul");
    strobe = 1'b0;
    cycle("simul_after");
    chk("simul acc", 32'(dut.acc), 32'd13);
    chk("simul spin_out", 32'(spin_out), 32'd1);
    chk("simul moved count", 32'(moved_seen), 32'd1);

    // Reset mid-count restarts the prescaler from zero.
    plus = 1'b0;
    do_reset("rst_mid_a");
    toggle(8'd20, "mid_seed");
    fast = 1'b0;
    plus = 1'b1;
    edges(5, "mid_count");
    chk("mid pre", 32'(dut.pre), 32'd5);
    do_reset("rst_mid_b");
    edges(7, "mid_after7");
    chk("mid 7 edges", 32'(spin_out), 32'd0);
    edges(1, "mid_after8");
    chk("mid 8th edge", 32'(spin_out), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rand_rst");
      end
      plus   = 1'($urandom_range(0, 1));
      minus  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) fast = ~fast;
      strobe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        spin_in = {~spin_in[8], 8'($urandom_range(0, 255))};
      end else begin
        spin_in[7:0] = 8'($urandom_range(0, 255));
      end
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dial_accumulator.md
# dial_accumulator

Converts player rotation requests into the absolute dial angle read by the MCR1 core's spinner input port. Sources are held left/right buttons and MiSTer spinner/mouse deltas. Sits between the HPS/keyboard input merge and the core's `input_1` low nibble. Output is registered; all state lives in a single fixed-point angle accumulator.

## Interface

Parameters:
- `ANGLE_W`, default 4: width of the output angle. The dial wraps modulo 2^ANGLE_W.
- `DIV_SLOW`, default 8: number of strobe edges per digital step when `fast`=0. Must be ≥1.
- `DIV_FAST`, default 2: number of strobe edges per digital step when `fast`=1. Must be ≥1.
- `FRAC_W`, default 3: fractional bits. One angle step equals 2^FRAC_W analog delta units.

Ports:
- `clk_sys` in 1: system clock (40 MHz in MCR1).
- `reset_n` in 1: asynchronous, active-low reset.
- `plus` in 1: held request to rotate clockwise (+).
- `minus` in 1: held request to rotate counter-clockwise (−).
- `fast` in 1: selects `DIV_FAST` instead of `DIV_SLOW`.
- `strobe` in 1: pacing tick. Its rising edge is used; this is the core's vsync.
- `spin_in` in 9: [7:0] is a signed two's-complement delta; [8] toggles on each new sample.
- `spin_out` out ANGLE_W: current angle, the accumulator's integer part.
- `moved` out 1: one-cycle pulse when `spin_out` changes.

## Operation

Accumulator:
- `acc` is ANGLE_W+FRAC_W bits, unsigned, with modulo wrap.
- `spin_out` = acc[ANGLE_W+FRAC_W-1:FRAC_W].

Digital path:
- A strobe rising edge (`strobe`=1 and `strobe_d`=0) is the pacing event.
- Direction: dir = +1 if `plus`&~`minus`; dir = −1 if `minus`&~`plus`; dir = 0 otherwise.
- If dir=0 at a strobe edge, the prescaler `pre` clears to 0.
- If dir≠0 at a strobe edge, `pre` increments. When `pre` reaches div−1, `pre` clears and the step is dir·2^FRAC_W. Here div is the value selected by `fast`, sampled at that edge.
- A change of `fast` mid-count takes effect at the next edge. If `pre` ≥ new div−1, the step fires at that edge.

Analog path:
- An update is detected when `armed`=1 and spin_in[8] ≠ `tog_d`.
- On an update, the delta sign-extended from spin_in[7:0] is added to `acc`.
- `tog_d` tracks spin_in[8] every cycle.
- `armed` is 0 at reset and sets on the first clock after reset release. The toggle level present at reset release is therefore never treated as an update.

Combining:
- A digital step and an analog delta in the same cycle are both added, as one sum, in that cycle.
- Sum width is ANGLE_W+FRAC_W. Overflow and underflow wrap silently.

`moved` is high for one cycle when the registered `spin_out` differs from its previous value.

Reset values: `acc`=0, `pre`=0, `strobe_d`=0, `tog_d`=0, `armed`=0, `spin_out`=0, `moved`=0.

## Timing

- Single clock domain. All inputs are treated as synchronous to `clk_sys`; upstream handles synchronisers.
- Rising edge of `strobe` at clock edge N: `acc` and `spin_out` update at edge N, and the new value is visible after edge N.
- `moved` asserts during the cycle after edge N, for exactly 1 cycle.
- Analog toggle seen at edge N: same latency as the strobe case.
- A strobe held high for many cycles counts once. Back-to-back strobe edges need `strobe` low for at least 1 cycle between them.
- Reset mid-count: `pre` and `acc` clear immediately (asynchronous). The first strobe edge after release starts a fresh count.

## Structure

- Package `dial_pkg` holds the default parameter constants: `DIAL_ANGLE_W`, `DIAL_DIV_SLOW`, `DIAL_DIV_FAST`, `DIAL_FRAC_W`.
- The package also holds the direction encoding as a typedef `dial_dir_t` with values NONE, CW, CCW.
- One sub-module is natural: `edge_toggle_det`. It contains the strobe rising-edge detector and the armed toggle-change detector, and is instantiated twice.
- The prescaler and accumulator stay in the top module.

## Test plan

- Reset: hold `reset_n`=0 with `spin_in`=9'h1FF → `spin_out`=0, `moved`=0. Release → no update, `spin_out` stays 0.
- Slow/fast stepping: `plus`=1, `fast`=0, 16 strobe edges → `spin_out`=2. Then `fast`=1, 8 edges → `spin_out`=6.
- Wrap and conflict: from 0, `minus`=1, 8 edges → `spin_out`=15. Then `plus`=`minus`=1, 20 edges → `spin_out` stays 15 and `pre`=0.
- Analog deltas: toggle with +12 → `spin_out`=1; toggle with +4 → 2; toggle with −24 → 15 (acc=120). `moved` pulses 3 times.
- Simultaneous events: acc=0, `fast`=1, `plus`=1, `pre`=1. A strobe edge and a toggle with +5 in the same cycle → acc=13, `spin_out`=1, single `moved` pulse.
- Reset mid-count: `plus`=1, `pre`=5 with `DIV_SLOW`=8, assert `reset_n`=0 → acc=0. After release, 7 edges → `spin_out`=0; 8th edge → 1.
